// File: rtl/cart_mem_sched.sv
// cart_mem_sched: owns SDRAM port A and shares it between the game loader's
// byte-write stream and the NES CPU bus.
//
// Loader bytes go into a small FIFO. They are issued one per slot, where a
// slot is the 4-cycle window opened by the clk edge that samples nes_ce == 1.
// All mem_* outputs change only on that edge and hold for the whole slot.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   nes_ce[1:0]           NES phase counter (0,1,2,3, one step per clk)
//   downloading           ROM download in progress
//   ld_write/addr/data    one-cycle loader write strobe with address and byte
//   cpu_addr/read/write/dout  CPU memory request, passed through in RUN
//   mem_addr/we/oe/din    registered port A request
//   cpu_hold              high in every state except RUN (and combinationally
//                         high as soon as downloading rises in RUN)
//   load_done             one-cycle pulse when the loader buffer has drained
//   overflow              sticky: a loader write arrived with the FIFO full
//
// Loader strobe: ld_write is a single-cycle, unconditional push with no ready
// return path. A strobe that finds the FIFO full (occupancy before this
// cycle's pop) is dropped and raises overflow.
module cart_mem_sched #(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        nes_ce,
  input  logic              downloading,
  input  logic              ld_write,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [7:0]        cpu_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [7:0]        mem_din,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and bookkeeping. Pointers wrap naturally (depth is 2^n).
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  logic             boundary;
  logic             issue_loader;
  logic             done_d;
  logic             ovf_clr;
  logic [ADDR_W-1:0] mem_addr_d;
  logic             mem_we_d, mem_oe_d;
  logic [7:0]       mem_din_d;

  assign boundary   = (nes_ce == 2'd1);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr_q];

  // A downloading rise takes effect on the same edge as the state change,
  // so a coincident slot boundary already follows the loader rule and no
  // CPU access slips through.
  assign issue_loader = downloading || (state_q == S_LOAD) || (state_q == S_DRAIN);

  assign push = ld_write && !fifo_full;
  assign pop  = boundary && issue_loader && !fifo_empty;

  assign cpu_hold = (state_q != S_RUN) || downloading;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {ld_addr, ld_data};
    end
  end

  // Next state, load_done pulse and overflow clear.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    ovf_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (downloading) begin
          state_d = S_LOAD;
          ovf_clr = 1'b1;
        end
      end
      S_LOAD: begin
        if (!downloading) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (downloading) begin
          state_d = S_LOAD;
          ovf_clr = 1'b1;
        end else if (boundary && fifo_empty) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (downloading) begin
          state_d = S_LOAD;
          ovf_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port A request for the next slot; only loaded on a boundary edge.
  always_comb begin
    mem_addr_d = mem_addr;
    mem_we_d   = mem_we;
    mem_oe_d   = mem_oe;
    mem_din_d  = mem_din;
    if (boundary) begin
      if (issue_loader) begin
        mem_oe_d = 1'b0;
        mem_we_d = !fifo_empty;
        if (!fifo_empty) begin
          mem_addr_d = head[ENT_W-1:8];
          mem_din_d  = head[7:0];
        end
      end else if (state_q == S_RUN) begin
        mem_addr_d = cpu_addr;
        mem_we_d   = cpu_write;
        mem_oe_d   = cpu_read;
        mem_din_d  = cpu_dout;
      end else begin
        mem_we_d = 1'b0;
        mem_oe_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_din   <= '0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_addr  <= mem_addr_d;
      mem_we    <= mem_we_d;
      mem_oe    <= mem_oe_d;
      mem_din   <= mem_din_d;
      load_done <= done_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // A dropped write wins over a clear in the same cycle.
      if (ld_write && fifo_full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cart_mem_sched.sv
// Bench for cart_mem_sched: directed loader/CPU scenarios, a queue-based
// reference model checked every cycle, plus literal expectations.
module tb_cart_mem_sched;

  localparam int ADDR_W = 22;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        nes_ce = 2'd0;
  logic              downloading = 1'b0;
  logic              ld_write = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [7:0]        ld_data = '0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              cpu_read = 1'b0;
  logic              cpu_write = 1'b0;
  logic [7:0]        cpu_dout = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, mem_oe;
  logic [7:0]        mem_din;
  logic              cpu_hold, load_done, overflow;

  cart_mem_sched #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .nes_ce(nes_ce), .downloading(downloading),
    .ld_write(ld_write), .ld_addr(ld_addr), .ld_data(ld_data),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_dout(cpu_dout), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_oe(mem_oe), .mem_din(mem_din), .cpu_hold(cpu_hold),
    .load_done(load_done), .overflow(overflow)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [ADDR_W+7:0] exp_q[$];   // model of the loader FIFO contents
  logic [ADDR_W+7:0] wr_log[$];  // writes seen on the port, one per slot
  int   done_cnt = 0;
  logic hold_at_done = 1'b1;
  logic [1:0] ce_at_done = 2'd0;

  // model outputs; mode: 0 idle, 1 loading, 2 draining, 3 cpu running
  int                m_mode = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic              m_we = 1'b0, m_oe = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
  logic [7:0]        m_din = '0;
  logic [ADDR_W+7:0] m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one slot decision per boundary, loader queue in exp_q.
  task automatic model_loop();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        exp_q.delete();
        m_mode = 0; m_addr = '0; m_we = 0; m_oe = 0; m_din = '0;
        m_done = 0; m_ovf = 0;
      end else begin
        int  n, nm;
        bit  bnd, ldr, drop;
        n    = exp_q.size();
        bnd  = (nes_ce == 2'd1);
        ldr  = downloading || m_mode == 1 || m_mode == 2;
        drop = ld_write && (n == DEPTH);
        m_done = 0;
        if (bnd) begin
          if (ldr) begin
            m_oe = 0;
            if (n > 0) begin
              m_e = exp_q.pop_front();
              m_addr = m_e[ADDR_W+7:8]; m_din = m_e[7:0]; m_we = 1;
            end else begin
              m_we = 0;
            end
          end else if (m_mode == 3) begin
            m_addr = cpu_addr; m_we = cpu_write; m_oe = cpu_read; m_din = cpu_dout;
          end else begin
            m_we = 0; m_oe = 0;
          end
        end
        if (ld_write && !drop) exp_q.push_back({ld_addr, ld_data});
        nm = m_mode;
        if (downloading) nm = 1;
        else if (m_mode == 1) nm = 2;
        else if (m_mode == 2 && bnd && n == 0) begin nm = 3; m_done = 1; end
        if (nm == 1 && m_mode != 1) m_ovf = 0;
        if (drop) m_ovf = 1;
        m_mode = nm;
      end
    end
  endtask

  // Compare every cycle on the falling edge, and log issued slots.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_oe", 32'(mem_oe), 32'(m_oe));
      chk("mem_din", 32'(mem_din), 32'(m_din));
      chk("cpu_hold", 32'(cpu_hold), 32'((m_mode != 3) || downloading));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (nes_ce == 2'd2 && mem_we) wr_log.push_back({mem_addr, mem_din});
      if (load_done) begin
        done_cnt++;
        hold_at_done = cpu_hold;
        ce_at_done = nes_ce;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
    nes_ce = nes_ce + 2'd1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ld_write = 1'b1; ld_addr = a; ld_data = d;
    cyc();
    ld_write = 1'b0;
  endtask

  task automatic align(input logic [1:0] ce);
    for (int i = 0; i < 4 && nes_ce != ce; i++) cyc();
  endtask

  // Run until the edge that just passed was a slot boundary.
  task automatic after_boundary();
    cyc();
    for (int i = 0; i < 4 && nes_ce != 2'd2; i++) cyc();
  endtask

  initial begin
    int base;
    reset_n = 1'b0;
    fork
      model_loop();
      compare_loop();
    join_none

    // reset values
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    cyc();
    reset_n = 1'b1;
    repeat (4) cyc();

    // three spaced loader writes
    downloading = 1'b1;
    base = wr_log.size();
    wr(22'h000000, 8'h4E); repeat (9) cyc();
    wr(22'h000001, 8'h45); repeat (9) cyc();
    wr(22'h200000, 8'h53); repeat (9) cyc();
    chk("spaced_count", 32'(wr_log.size() - base), 32'd3);
    if (wr_log.size() >= base + 3) begin
      chk("spaced_w0", 32'(wr_log[base]),     {2'b0, 22'h000000, 8'h4E});
      chk("spaced_w1", 32'(wr_log[base + 1]), {2'b0, 22'h000001, 8'h45});
      chk("spaced_w2", 32'(wr_log[base + 2]), {2'b0, 22'h200000, 8'h53});
    end

    // five back-to-back writes starting on a boundary: 5th dropped
    align(2'd1);
    base = wr_log.size();
    for (int i = 0; i < 5; i++) wr(22'(32'h100 + i), 8'(8'h10 + i));
    repeat (20) cyc();
    @(negedge clk);
    chk("ovf_count", 32'(wr_log.size() - base), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    if (wr_log.size() >= base + 4)
      chk("ovf_last", 32'(wr_log[base + 3]), {2'b0, 22'h000103, 8'h13});

    // download ends with two entries queued
    align(2'd1);
    base = wr_log.size();
    wr(22'h000040, 8'hC1);
    wr(22'h000041, 8'hC2);
    downloading = 1'b0;
    repeat (16) cyc();
    chk("drain_count", 32'(wr_log.size() - base), 32'd2);
    if (wr_log.size() >= base + 2)
      chk("drain_w1", 32'(wr_log[base + 1]), {2'b0, 22'h000041, 8'hC2});
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_hold", 32'(hold_at_done), 32'd0);
    chk("done_phase", 32'(ce_at_done), 32'd2);

    // CPU read then write in RUN
    cpu_read = 1'b1; cpu_addr = 22'h008000;
    after_boundary();
    @(negedge clk);
    chk("run_oe", 32'(mem_oe), 32'd1);
    chk("run_addr", 32'(mem_addr), 32'h008000);
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 22'h008001; cpu_dout = 8'hA5;
    after_boundary();
    @(negedge clk);
    chk("run_we", 32'(mem_we), 32'd1);
    chk("run_din", 32'(mem_din), 32'hA5);

    // download rises on a boundary cycle while the CPU is writing
    align(2'd1);
    downloading = 1'b1;
    #1;
    chk("rise_hold", 32'(cpu_hold), 32'd1);
    cyc();
    @(negedge clk);
    chk("rise_no_cpu_we", 32'(mem_we), 32'd0);
    chk("rise_ovf_clr", 32'(overflow), 32'd0);
    cpu_write = 1'b0;

    // reset during LOAD with three entries queued and a write in flight
    align(2'd2);
    wr(22'h000200, 8'hD0);
    wr(22'h000201, 8'hD1);
    wr(22'h000202, 8'hD2);
    wr(22'h000203, 8'hD3);
    #1;
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    downloading = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_din", 32'(mem_din), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (12) cyc();
    base = wr_log.size();
    downloading = 1'b1;
    repeat (12) cyc();
    chk("post_rst_empty", 32'(wr_log.size() - base), 32'd0);
    downloading = 1'b0;
    repeat (12) cyc();
    chk("post_rst_done", 32'(done_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cart_mem_sched.md
# cart_mem_sched

Slot scheduler for SDRAM port A of the NES core. It owns the port and shares it between two sources: the game loader's byte-write stream and the NES CPU's memory bus. Loader bytes are buffered in a small FIFO and issued only on slot boundaries aligned to `nes_ce`. It sits between `GameLoader`/`NES` and `sdram`, and replaces ad-hoc loader write latching and address muxing in the top level.

## Interface
Parameters:
- `ADDR_W`, 22: byte address width of port A.
- `FIFO_DEPTH`, 4: loader write FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk`, in, 1: system clock, same as the NES core clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `nes_ce`, in, 2: NES phase counter. Counts 0,1,2,3 and wraps, one step per `clk`.
- `downloading`, in, 1: ROM download in progress (from `data_io`).
- `ld_write`, in, 1: one-cycle loader write strobe.
- `ld_addr`, in, ADDR_W: loader write address.
- `ld_data`, in, 8: loader write data.
- `cpu_addr`, in, ADDR_W: CPU address.
- `cpu_read`, in, 1: CPU read request.
- `cpu_write`, in, 1: CPU write request.
- `cpu_dout`, in, 8: CPU write data.
- `mem_addr`, out, ADDR_W: port A address.
- `mem_we`, out, 1: port A write enable.
- `mem_oe`, out, 1: port A output enable.
- `mem_din`, out, 8: port A write data.
- `cpu_hold`, out, 1: CPU must be held in reset. High in every state except RUN.
- `load_done`, out, 1: one-cycle pulse when the last buffered loader byte has been issued.
- `overflow`, out, 1: sticky flag. A loader write arrived while the FIFO was full.

## Operation
- Slot boundary: the `clk` edge where `nes_ce == 1`. All `mem_*` outputs are registered only on this edge, then held for 4 cycles (one slot). This matches the `clkref = nes_ce[1]` sampling in `sdram`.
- FIFO:
  - A `ld_write` pushes `{ld_addr, ld_data}` in the same cycle.
  - The slot-boundary issue logic pops one entry.
  - A push and a pop in the same cycle are both honoured; the occupancy count is unchanged.
  - A push when full is dropped and sets `overflow`.
  - A pop when empty is impossible by construction.
- State machine:
  - IDLE (reset state): `cpu_hold` = 1, port idle. On `downloading` = 1 go to LOAD and clear `overflow`.
  - LOAD: at each slot boundary, if the FIFO is non-empty, pop and drive `mem_we` = 1, `mem_oe` = 0 with the popped addr/data. Otherwise drive `mem_we` = 0, `mem_oe` = 0. CPU requests are ignored. On `downloading` = 0 go to DRAIN.
  - DRAIN: same issue rule as LOAD. At the first slot boundary where the FIFO is empty, pulse `load_done` and go to RUN. If `downloading` = 1 again, return to LOAD without flushing the FIFO.
  - RUN: `cpu_hold` = 0. At each slot boundary the outputs are `mem_addr` = `cpu_addr`, `mem_we` = `cpu_write`, `mem_oe` = `cpu_read`, `mem_din` = `cpu_dout`. On `downloading` = 1 go to LOAD and assert `cpu_hold` in the same cycle.
- Loader writes arriving in RUN (no `downloading`) are still pushed but not issued until LOAD/DRAIN.
- The `cpu_read` and `cpu_write` passthrough is not qualified further. The CPU never asserts both at once.
- Address and data widths are passed through unmodified. No zero-extension is done here; the top level prepends `3'b000` for `sdram`.

## Timing
- Reset values:
  - `mem_addr` = 0, `mem_we` = 0, `mem_oe` = 0, `mem_din` = 0.
  - `cpu_hold` = 1, `load_done` = 0, `overflow` = 0.
  - FIFO empty, state IDLE.
- Loader latency: a byte pushed at cycle t appears on `mem_*` at the first slot boundary strictly after t, plus the queue ahead of it. With an empty FIFO, a push in the cycle where `nes_ce == 1` issues at the next boundary (4 cycles later), not the current one.
- Each issued entry occupies exactly one slot. Sustained drain is 1 byte per 4 clk.
- `load_done` is asserted on the boundary edge itself and is high for 1 cycle. `cpu_hold` falls on that same edge.
- `reset_n` low mid-operation: all state and the FIFO are cleared immediately (asynchronously), and any in-flight `mem_we` drops.
- A `downloading` rise and a slot boundary in the same cycle: the state moves to LOAD, and that boundary already uses the LOAD issue rule, so no CPU access is issued.

## Test plan
- Reset, then `downloading` = 1 and three `ld_write`s (addr 0x000000/0x000001/0x200000, data 0x4E/0x45/0x53) spaced 10 cycles apart → three `mem_we` slots, each 4 cycles, in order, with matching addr/data. `mem_oe` stays 0.
- Five `ld_write`s on consecutive cycles with FIFO_DEPTH = 4 → 5th dropped, `overflow` = 1, exactly four writes issued. `overflow` clears on the next `downloading` rise.
- `downloading` falls with 2 entries queued → 2 more write slots, then a `load_done` pulse on the boundary edge, and `cpu_hold` falls in the same cycle.
- RUN with `cpu_read` = 1, `cpu_addr` = 0x008000 → at the next boundary `mem_oe` = 1 and `mem_addr` = 0x008000, held 4 cycles. A `cpu_write` of 0xA5 produces `mem_we` = 1, `mem_din` = 0xA5.
- `downloading` rises in RUN while the CPU is writing → `cpu_hold` = 1 in the same cycle, and no CPU write is issued at the following boundary.
- `reset_n` pulsed low during LOAD with 3 entries queued → outputs return to reset values immediately. After release the FIFO is empty and the state is IDLE.
